// File: rtl/trace_request_queue.sv
// Time-ordered trace request queue: buffers parsed requests and releases each one once the cycle counter reaches its trace time.
// Optional TRQ_TIME_SKIP_EN lets the cycle counter jump forward over idle gaps and reports each jump on skip_pulse.
package global_defs;
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_NOP    = 2'd3
  } parsed_op_t;
endpackage

module trace_request_queue
  import global_defs::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIME_WIDTH    = 64,
  parameter int DEPTH         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_WIDTH-1:0]      in_time,
  input  parsed_op_t                 in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]   in_address,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_WIDTH-1:0]      out_time,
  output parsed_op_t                 out_opcode,
  output logic [ADDRESS_WIDTH-1:0]   out_address,
  output logic [TIME_WIDTH-1:0]      clock_count,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       order_err
`ifdef TRQ_TIME_SKIP_EN
  ,
  output logic                       skip_pulse
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TIME_WIDTH-1:0]    time_mem [DEPTH];
  parsed_op_t               op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];

  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [TIME_WIDTH-1:0]    clk_cnt_q, clk_cnt_d;
  logic [TIME_WIDTH-1:0]    last_time_q, last_time_d;
  logic                     order_err_q, order_err_d;
  logic [TIME_WIDTH-1:0]    hold_time_q, hold_time_d;
  parsed_op_t               hold_op_q, hold_op_d;
  logic [ADDRESS_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic                     skip_q, skip_d;

  logic                     push, pop, late;
  logic [TIME_WIDTH-1:0]    head_time, wr_time;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign in_ready    = !full;
  assign count       = count_q;
  assign clock_count = clk_cnt_q;
  assign order_err   = order_err_q;
  assign head_time   = time_mem[rptr_q];
  assign out_valid   = !empty && (head_time <= clk_cnt_q);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  // A late request is clamped to the last accepted time so release order stays monotonic.
  assign late        = in_time < last_time_q;
  assign wr_time     = late ? last_time_q : in_time;

  assign out_time    = empty ? hold_time_q : head_time;
  assign out_opcode  = empty ? hold_op_q   : op_mem[rptr_q];
  assign out_address = empty ? hold_addr_q : addr_mem[rptr_q];

  always_comb begin
    wptr_d      = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d     = count_q;
    last_time_d = push ? wr_time : last_time_q;
    order_err_d = order_err_q | (push && late);
    hold_time_d = hold_time_q;
    hold_op_d   = hold_op_q;
    hold_addr_d = hold_addr_q;
    clk_cnt_d   = clk_cnt_q + TIME_WIDTH'(1);
    skip_d      = 1'b0;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      hold_time_d = head_time;
      hold_op_d   = op_mem[rptr_q];
      hold_addr_d = addr_mem[rptr_q];
    end
`ifdef TRQ_TIME_SKIP_EN
    if (empty && push && (in_time > clk_cnt_q + TIME_WIDTH'(1))) begin
      clk_cnt_d = in_time - TIME_WIDTH'(1);
      skip_d    = 1'b1;
    end else if (!empty && !push && (head_time > clk_cnt_q + TIME_WIDTH'(1))) begin
      clk_cnt_d = head_time - TIME_WIDTH'(1);
      skip_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      time_mem[wptr_q] <= wr_time;
      op_mem[wptr_q]   <= in_opcode;
      addr_mem[wptr_q] <= in_address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      clk_cnt_q   <= '0;
      last_time_q <= '0;
      order_err_q <= 1'b0;
      hold_time_q <= '0;
      hold_op_q   <= OP_READ;
      hold_addr_q <= '0;
      skip_q      <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      clk_cnt_q   <= clk_cnt_d;
      last_time_q <= last_time_d;
      order_err_q <= order_err_d;
      hold_time_q <= hold_time_d;
      hold_op_q   <= hold_op_d;
      hold_addr_q <= hold_addr_d;
      skip_q      <= skip_d;
    end
  end

`ifdef TRQ_TIME_SKIP_EN
  assign skip_pulse = skip_q;
`else
  logic unused_skip;
  assign unused_skip = skip_q;
`endif

endmodule

// File: tb/tb_trace_request_queue.sv
// Scoreboard bench for trace_request_queue: a queue-based reference model predicts every output each cycle.
// Builds with or without TRQ_TIME_SKIP_EN.
module tb_trace_request_queue;
  import global_defs::*;

  localparam int AW    = 32;
  localparam int TW    = 64;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [TW-1:0]  in_time, out_time, clock_count;
  parsed_op_t     in_opcode, out_opcode;
  logic [AW-1:0]  in_address, out_address;
  logic [4:0]     count;
  logic           full, empty, order_err;
`ifdef TRQ_TIME_SKIP_EN
  logic           skip_pulse;
`endif

  trace_request_queue #(.ADDRESS_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_opcode(in_opcode), .in_address(in_address),
    .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
    .out_opcode(out_opcode), .out_address(out_address),
    .clock_count(clock_count), .count(count), .full(full), .empty(empty),
    .order_err(order_err)
`ifdef TRQ_TIME_SKIP_EN
    , .skip_pulse(skip_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] t;
    parsed_op_t    op;
    logic [AW-1:0] a;
  } entry_t;

  entry_t        exp_q[$];
  entry_t        last_out;
  logic [TW-1:0] mclk, last_t;
  bit            oerr_m, skip_m, hold_req;
  bit            ready_m, ov_m, push_m, pop_m;
  entry_t        ne;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_out = '{t: '0, op: OP_READ, a: '0};
    mclk     = '0;
    last_t   = '0;
    oerr_m   = 1'b0;
    skip_m   = 1'b0;
    hold_req = 1'b0;
  endtask

  // Compare DUT against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else begin
      ready_m = exp_q.size() < DEPTH;
      ov_m    = (exp_q.size() != 0) && (exp_q[0].t <= mclk);
      check("clock_count", clock_count, mclk);
      check("count", TW'(count), TW'(exp_q.size()));
      check("empty", TW'(empty), TW'(exp_q.size() == 0));
      check("full", TW'(full), TW'(exp_q.size() == DEPTH));
      check("in_ready", TW'(in_ready), TW'(ready_m));
      check("out_valid", TW'(out_valid), TW'(ov_m));
      check("order_err", TW'(order_err), TW'(oerr_m));
`ifdef TRQ_TIME_SKIP_EN
      check("skip_pulse", TW'(skip_pulse), TW'(skip_m));
`endif
      if (exp_q.size() != 0) begin
        check("out_time", out_time, exp_q[0].t);
        check("out_opcode", TW'(out_opcode), TW'(exp_q[0].op));
        check("out_address", TW'(out_address), TW'(exp_q[0].a));
      end else begin
        check("hold_time", out_time, last_out.t);
        check("hold_address", TW'(out_address), TW'(last_out.a));
      end
      push_m   = in_valid && ready_m;
      pop_m    = ov_m && out_ready;
      hold_req = in_valid && !ready_m;
      skip_m   = 1'b0;
`ifdef TRQ_TIME_SKIP_EN
      if (exp_q.size() == 0 && push_m && in_time > mclk + 1) begin
        skip_m = 1'b1;
      end else if (exp_q.size() != 0 && !push_m && exp_q[0].t > mclk + 1) begin
        skip_m = 1'b1;
      end
`endif
      if (pop_m) last_out = exp_q.pop_front();
      if (push_m) begin
        if (in_time < last_t) oerr_m = 1'b1;
        else last_t = in_time;
        ne = '{t: last_t, op: in_opcode, a: in_address};
        exp_q.push_back(ne);
      end
      if (skip_m) mclk = (exp_q.size() == 1 && push_m) ? in_time - 1 : exp_q[0].t - 1;
      else mclk = mclk + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    if (chk) begin
      check("rst_count", TW'(count), 0);
      check("rst_empty", TW'(empty), 1);
      check("rst_out_valid", TW'(out_valid), 0);
      check("rst_clock", clock_count, 0);
      check("rst_out_time", out_time, 0);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [TW-1:0] t, input parsed_op_t op, input logic [AW-1:0] a);
    in_valid   = 1'b1;
    in_time    = t;
    in_opcode  = op;
    in_address = a;
  endtask

  task automatic wait_clock(input logic [TW-1:0] target);
    for (int i = 0; i < 200 && clock_count != target; i++) cyc();
    check("wait_clock", clock_count, target);
  endtask

  task automatic wait_valid(input int max, input string name);
    for (int i = 0; i < max && !out_valid; i++) cyc();
    check(name, TW'(out_valid), 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && !empty; i++) cyc();
    check("drain_empty", TW'(empty), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_time = '0; in_opcode = OP_READ; in_address = '0;
    do_reset(1'b1);

    // Timed release of a single request.
    out_ready = 1'b1;
    wait_clock(3);
    drive(20, OP_READ, 32'h0000_1A40);
    cyc();
    in_valid = 1'b0;
    wait_valid(100, "release_timeout");
    check("release_cycle", clock_count, 20);
    check("release_addr", TW'(out_address), 64'h1A40);
    cyc();
    check("release_empty", TW'(empty), 1);

    // Mid-stream reset with five requests queued.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(500, OP_WRITE, AW'(i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("pre_rst_count", TW'(count), 5);
    do_reset(1'b1);
    cyc();
    check("post_rst_clock", clock_count, 1);

    // Out-of-order time is clamped and blocks behind its predecessor.
    do_reset(1'b0);
    out_ready = 1'b1;
    drive(50, OP_WRITE, 32'hA);
    cyc();
    drive(10, OP_IFETCH, 32'hB);
    cyc();
    in_valid = 1'b0;
    check("order_err", TW'(order_err), 1);
    wait_valid(100, "order_timeout");
    check("order_first_cycle", clock_count, 50);
    check("order_first_addr", TW'(out_address), 64'hA);
    cyc();
    check("order_second_valid", TW'(out_valid), 1);
    check("order_second_time", out_time, 50);
    check("order_second_addr", TW'(out_address), 64'hB);
    cyc();
    check("order_empty", TW'(empty), 1);

    // Fill to full, hold the 17th request, then free one slot.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(0, OP_READ, AW'(i));
      cyc();
    end
    drive(0, OP_WRITE, 32'd16);
    check("full_flag", TW'(full), 1);
    check("full_in_ready", TW'(in_ready), 0);
    cyc();
    cyc();
    check("full_held_count", TW'(count), 16);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("after_pop_count", TW'(count), 15);
    cyc();
    in_valid = 1'b0;
    check("refill_count", TW'(count), 16);
    drain();

    // Simultaneous push and pop across pointer wrap.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, OP_READ, 32'h100 + AW'(i));
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(0, parsed_op_t'(i % 4), 32'h200 + AW'(i));
      cyc();
    end
    in_valid = 1'b0;
    check("simul_count", TW'(count), 4);
    drain();

    // Large gap: skip (if enabled) or natural counting.
    do_reset(1'b0);
    out_ready = 1'b1;
    wait_clock(7);
    drive(1000, OP_READ, 32'hC0DE);
    cyc();
    in_valid = 1'b0;
`ifdef TRQ_TIME_SKIP_EN
    check("skip_clock", clock_count, 999);
    check("skip_pulse_hi", TW'(skip_pulse), 1);
    cyc();
    check("skip_pulse_lo", TW'(skip_pulse), 0);
    check("skip_valid", TW'(out_valid), 1);
`else
    wait_valid(1100, "gap_timeout");
`endif
    check("gap_release_cycle", clock_count, 1000);
    cyc();

    // Randomized traffic against the model.
    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      if (!hold_req) begin
        in_valid   = ($urandom_range(0, 2) != 0);
        in_opcode  = parsed_op_t'($urandom_range(0, 3));
        in_address = $urandom;
        if ($urandom_range(0, 7) == 0) in_time = (clock_count > 5) ? clock_count - 5 : '0;
        else in_time = clock_count + TW'($urandom_range(0, 25));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trace_request_queue.md
Name: trace_request_queue

Overview:
- Parametrised successor to the trace parser front end.
- Buffers parsed trace requests (arrival time, opcode, address) in a DEPTH-entry in-order queue.
- Keeps the simulation cycle counter and releases each request to the memory-controller scheduler only once the current cycle reaches its trace time.
- Sits between the trace parser (producer) and the DRAM command scheduler (consumer).

Parameters:
- ADDRESS_WIDTH, 32: width of request address.
- TIME_WIDTH, 64: width of trace time and cycle counter.
- DEPTH, 16: queue entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a request
- in_ready  output  1  queue can accept (= !full)
- in_time  input  TIME_WIDTH  trace arrival cycle of request
- in_opcode  input  parsed_op_t  request opcode from global_defs
- in_address  input  ADDRESS_WIDTH  request address
- out_valid  output  1  head entry present and due
- out_ready  input  1  scheduler accepts head
- out_time  output  TIME_WIDTH  head entry time
- out_opcode  output  parsed_op_t  head entry opcode
- out_address  output  ADDRESS_WIDTH  head entry address
- clock_count  output  TIME_WIDTH  current simulation cycle
- count  output  $clog2(DEPTH)+1  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- order_err  output  1  sticky: non-monotonic input time seen

Behaviour:
- Reset (rst_n low, asynchronous):
  - clock_count=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, order_err=0.
  - Pointers = 0.
  - out_time/out_opcode/out_address = 0.
  - Queue contents don't care.
- Reset mid-operation discards all queued entries; the first cycle after release behaves exactly as after power-up.
- clock_count increments by 1 every clk edge out of reset; wraps modulo 2^TIME_WIDTH (wrap is not a supported scenario).
- Push: in_valid && in_ready at clk edge writes {time, opcode, address} at the write pointer; wptr+1 mod DEPTH.
- Pop: out_valid && out_ready at clk edge advances rptr+1 mod DEPTH.
- Simultaneous push and pop:
  - Allowed when not full; count unchanged.
  - When full, in_ready=0, so a same-cycle pop does not enable a push; the push is accepted the following cycle.
- Latency: an entry pushed at edge N is visible at the head no earlier than after edge N (no combinational in-to-out bypass).
- out_valid = !empty && (head.time <= clock_count); purely combinational from registered state.
- out_* always reflect the head entry when !empty; they hold last values when empty.
- Strict in-order release: a later entry whose time is due never bypasses a head entry that is not due.
- Order check:
  - Track last accepted time (reset 0).
  - If an accepted in_time < last accepted time, store the entry with time = last accepted time and set order_err.
  - order_err clears only on reset.
- A request whose in_time <= clock_count at push is eligible on the first cycle it reaches the head.
- Producer/consumer handshake rules:
  - Producer must hold in_* stable while in_valid && !in_ready.
  - out_valid never deasserts without a pop, unless reset occurs.

Optional Feature:
- Macro TRQ_TIME_SKIP_EN.
- Defined:
  - When empty and out_valid=0, and in_valid && in_ready with in_time > clock_count+1, clock_count loads in_time-1 at that edge instead of incrementing. The pushed entry is therefore due on the next cycle.
  - Also when !empty and head.time > clock_count+1 and no push is occurring, clock_count loads head.time-1.
  - Skips are reported through an extra output skip_pulse (1 bit, one-cycle high per jump, reset 0).
- Undefined: clock_count always increments by exactly 1; no skip_pulse port.

Test Plan:
- Reset: drive rst_n=0 mid-stream with 5 entries queued -> count=0, empty=1, out_valid=0, clock_count=0 immediately (asynchronous); after release clock_count increments from 0.
- Timed release: push {time=20, READ, 0x0000_1A40} at cycle 3, out_ready=1 -> out_valid first high when clock_count=20; popped that edge; empty=1 next cycle.
- In-order block: push {time=50, WRITE, 0xA}, then {time=10, IFETCH, 0xB} -> second stored with time 50, order_err=1; both released at cycle 50 on consecutive cycles with out_ready=1.
- Full / backpressure: DEPTH=16, out_ready=0, push 17 due entries -> full=1, in_ready=0 after 16th; 17th held. Raise out_ready one cycle -> pop; 17th accepted next edge; count returns to 16.
- Simultaneous: count=4, push and pop same edge -> count stays 4; pointers wrap correctly across index 15->0 over 40 operations; data order preserved.
- TRQ_TIME_SKIP_EN: empty queue at clock_count=7, push time=1000 -> clock_count=999 next cycle, skip_pulse one cycle, out_valid at 1000. Without macro: out_valid at clock_count=1000 after natural counting.
